// File: rtl/kanade32_imem_resp_if.sv
// Fetch-side request/response bundle for the KANADE32 instruction-memory responder.
// The fetch unit drives the master side and the responder implements the slave side.
interface kanade32_imem_resp_if;
    logic        req_valid;
    logic [29:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/kanade32_imem_resp.sv
// KANADE32 instruction-memory responder: fixed-latency in-order reads with a response FIFO and flush.
// Define KANADE32_IMEM_INIT_EN when the array image is preloaded at time 0; otherwise every read returns zero.
module kanade32_imem_resp #(
    parameter int    ADDR_W   = 10,
    parameter int    LATENCY  = 2,
    parameter int    DEPTH    = 4,
    parameter string IMEM_HEX = "imem.hex"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    kanade32_imem_resp_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              accept;
    logic              respond;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rd_word;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic              fifo_wr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       fifo_mem [DEPTH];
    logic [31:0]       imem [2**ADDR_W];

    // Upper address bits are deliberately ignored so fetches wrap within the array.
    logic unused_addr;
    assign unused_addr = ^bus.req_addr;

`ifndef KANADE32_IMEM_INIT_EN
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) imem[i] = '0;
    end
`endif

    assign rd_word = imem[bus.req_addr[ADDR_W-1:0]];

    // Readiness looks only at the registered count, never at this cycle's respond.
    assign req_ready = !reset && !flush && (cnt < CNT_W'(DEPTH));
    assign rsp_valid = (fifo_cnt != '0) && !flush && !reset;
    assign accept    = bus.req_valid && req_ready;
    assign respond   = rsp_valid && bus.rsp_ready;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = fifo_mem[rd_ptr];

    // The accept edge counts as the first stage; the FIFO write is the last.
    if (LATENCY == 1) begin : g_direct
        assign wr_en   = accept;
        assign wr_data = rd_word;
    end else begin : g_pipe
        logic [LATENCY-2:0] pipe_valid;
        logic [31:0]        pipe_data [LATENCY-1];

        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                pipe_valid <= '0;
            end else begin
                pipe_valid[0] <= accept;
                for (int i = 1; i < LATENCY - 1; i++) pipe_valid[i] <= pipe_valid[i-1];
            end
        end

        always_ff @(posedge clk) begin
            pipe_data[0] <= rd_word;
            for (int i = 1; i < LATENCY - 1; i++) pipe_data[i] <= pipe_data[i-1];
        end

        assign wr_en   = pipe_valid[LATENCY-2];
        assign wr_data = pipe_data[LATENCY-2];
    end

    assign fifo_wr = wr_en && !flush;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            cnt      <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= next_ptr(wr_ptr);
            if (respond) rd_ptr <= next_ptr(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(respond);
            cnt      <= cnt + CNT_W'(accept) - CNT_W'(respond);
        end
    end

    // NOTE: the small response FIFO is cleared on reset so rsp_data reads zero afterwards;
    // the instruction array is never reset and keeps its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else if (fifo_wr) begin
            fifo_mem[wr_ptr] <= wr_data;
        end
    end

endmodule
